// File: rtl/gate_arbiter.sv
// Shared W-bit logic unit (NOT/NAND/AND/OR/XOR) arbitrated between NREQ requesters.
// Define PRIORITY_FIXED_EN for fixed lowest-index-wins priority; default is round-robin.
module gate_arbiter #(
    parameter int W    = 16,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    op,
    input  logic [W*NREQ-1:0]    a,
    input  logic [W*NREQ-1:0]    b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [W-1:0]         result,
    output logic                 err,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    stateReg;
    logic [IW-1:0] rrPtrReg;
    logic [2:0]    opReg;
    logic [W-1:0]  aReg;
    logic [W-1:0]  bReg;

    logic [2:0]    opArr [NREQ];
    logic [W-1:0]  aArr  [NREQ];
    logic [W-1:0]  bArr  [NREQ];

    logic          anyReq;
    logic [IW-1:0] winIdx;
    logic [W-1:0]  aluResult;
    logic          aluErr;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : gUnpack
            assign opArr[gi] = op[3*gi +: 3];
            assign aArr[gi]  = a[W*gi +: W];
            assign bArr[gi]  = b[W*gi +: W];
        end
    endgenerate

    assign anyReq = |req;
    assign busy   = (stateReg != IDLE);

`ifdef PRIORITY_FIXED_EN
    // Descending scan so the lowest asserted index is the last one written.
    always_comb begin
        winIdx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) winIdx = IW'(i);
        end
    end
`else
    // Scan starts just past the previous winner and wraps, so the previous
    // winner is considered last.
    always_comb begin
        logic found;
        int   idx;
        winIdx = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rrPtrReg) + i) % NREQ;
            if (!found && req[idx]) begin
                winIdx = IW'(idx);
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        aluResult = '0;
        aluErr    = 1'b0;
        case (opReg)
            3'd0:    aluResult = ~aReg;
            3'd1:    aluResult = ~(aReg & bReg);
            3'd2:    aluResult = aReg & bReg;
            3'd3:    aluResult = aReg | bReg;
            3'd4:    aluResult = aReg ^ bReg;
            default: aluErr    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            rrPtrReg <= IW'(NREQ - 1);
            opReg    <= '0;
            aReg     <= '0;
            bReg     <= '0;
            gnt      <= '0;
            done     <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    done <= '0;
                    if (anyReq) begin
                        opReg    <= opArr[winIdx];
                        aReg     <= aArr[winIdx];
                        bReg     <= bArr[winIdx];
                        gnt      <= NREQ'(1) << winIdx;
                        err      <= 1'b0;
`ifndef PRIORITY_FIXED_EN
                        rrPtrReg <= winIdx;
`endif
                        stateReg <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal opcodes still complete with a zero result and err.
                    result   <= aluResult;
                    err      <= aluErr;
                    done     <= gnt;
                    stateReg <= RESP;
                end
                RESP: begin
                    done     <= '0;
                    gnt      <= '0;
                    stateReg <= IDLE;
                end
                default: begin
                    done     <= '0;
                    gnt      <= '0;
                    stateReg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gate_arbiter.sv
// Directed self-checking bench for gate_arbiter (W=16, NREQ=4).
module tb_gate_arbiter;
    localparam int W    = 16;
    localparam int NREQ = 4;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [3*NREQ-1:0]    op;
    logic [W*NREQ-1:0]    a;
    logic [W*NREQ-1:0]    b;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [W-1:0]         result;
    logic                 err;
    logic                 busy;

    int checkCount = 0;
    int failCount  = 0;

    gate_arbiter #(.W(W), .NREQ(NREQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .op     (op),
        .a      (a),
        .b      (b),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .err    (err),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int idx, input logic [2:0] opc, input logic [W-1:0] av, input logic [W-1:0] bv);
        op[3*idx +: 3] = opc;
        a[W*idx +: W]  = av;
        b[W*idx +: W]  = bv;
        req[idx]       = 1'b1;
    endtask

    // One full transaction for a single requester, dropping req as done is seen.
    task automatic doOp(input string tag, input int idx, input logic [2:0] opc,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] expResult, input logic expErr);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << idx;
        setReq(idx, opc, av, bv);
        tick();
        checkEq({tag, ".gnt"}, 32'(gnt), 32'(oh));
        checkEq({tag, ".busy"}, 32'(busy), 32'd1);
        tick();
        checkEq({tag, ".done"}, 32'(done), 32'(oh));
        checkEq({tag, ".result"}, 32'(result), 32'(expResult));
        checkEq({tag, ".err"}, 32'(err), 32'(expErr));
        req[idx] = 1'b0;
        tick();
        checkEq({tag, ".idleGnt"}, 32'(gnt), 32'd0);
        checkEq({tag, ".idleDone"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] oh;
        logic [W-1:0]    doneSeen;
        int              order [5];
        order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        checkEq("rst.gnt", 32'(gnt), 32'd0);
        checkEq("rst.done", 32'(done), 32'd0);
        checkEq("rst.result", 32'(result), 32'd0);
        checkEq("rst.err", 32'(err), 32'd0);
        checkEq("rst.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        checkEq("idle.gnt", 32'(gnt), 32'd0);

        doOp("and0",  0, 3'd2, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0);
        checkEq("and0.held", 32'(result), 32'h000F);
        doOp("not2",  2, 3'd0, 16'h1234, 16'h0000, 16'hEDCB, 1'b0);
        doOp("xor2",  2, 3'd4, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0);
        doOp("nand1", 1, 3'd1, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0);
        doOp("or3",   3, 3'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0);
        doOp("ill6",  1, 3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1);
        checkEq("ill6.errHeld", 32'(err), 32'd1);
        doOp("clr1",  1, 3'd2, 16'hFFFF, 16'h1234, 16'h1234, 1'b0);
        doOp("ill7",  0, 3'd7, 16'h1111, 16'h2222, 16'h0000, 1'b1);
        doOp("last3", 3, 3'd2, 16'hFFFF, 16'h5A5A, 16'h5A5A, 1'b0);

`ifdef PRIORITY_FIXED_EN
        setReq(0, 3'd2, 16'hFFFF, 16'h00AA);
        setReq(3, 3'd2, 16'hFFFF, 16'hBB00);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkEq($sformatf("fix%0d.gnt", k), 32'(gnt), 32'h1);
            tick();
            checkEq($sformatf("fix%0d.result", k), 32'(result), 32'h00AA);
            if (k == 3) req = '0;
            tick();
        end
`else
        // Previous grant was 3, so rotation starts from 0.
        for (int i = 0; i < NREQ; i++) begin
            setReq(i, 3'd2, 16'hFFFF, 16'(16'h1111 * (i + 1)));
        end
        for (int k = 0; k < 5; k++) begin
            oh = NREQ'(1) << order[k];
            tick();
            checkEq($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(oh));
            tick();
            checkEq($sformatf("rr%0d.done", k), 32'(done), 32'(oh));
            checkEq($sformatf("rr%0d.result", k), 32'(result), 32'(16'h1111 * (order[k] + 1)));
            if (k == 4) req = '0;
            tick();
            checkEq($sformatf("rr%0d.idle", k), 32'(done | gnt), 32'd0);
        end
`endif

        // Async reset in EXEC discards the pending op.
        setReq(3, 3'd2, 16'hFFFF, 16'h0BAD);
        tick();
        checkEq("rstmid.gnt", 32'(gnt), 32'h8);
        #1 rst_n = 1'b0;
        #1;
        checkEq("rstmid.gnt0", 32'(gnt), 32'd0);
        checkEq("rstmid.done0", 32'(done), 32'd0);
        checkEq("rstmid.result0", 32'(result), 32'd0);
        checkEq("rstmid.busy0", 32'(busy), 32'd0);
        req = '0;
        tick();
        rst_n = 1'b1;
        doneSeen = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            doneSeen = doneSeen | W'(done);
        end
        checkEq("rstmid.noDone", 32'(doneSeen), 32'd0);

        // Req dropped and operands changed after capture are ignored.
        setReq(1, 3'd4, 16'h00FF, 16'h0FF0);
        tick();
        checkEq("drop.gnt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        a[W*1 +: W] = 16'h0000;
        op[3*1 +: 3] = 3'd7;
        tick();
        checkEq("drop.done", 32'(done), 32'h2);
        checkEq("drop.result", 32'(result), 32'h0F0F);
        checkEq("drop.err", 32'(err), 32'd0);
        tick();
        checkEq("drop.idle", 32'(done | gnt), 32'd0);
        tick();
        checkEq("drop.noRegrant", 32'(gnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
